// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED PIO pattern sequencer.
package led_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2,
    BLANK = 2'd3
  } led_seq_state_e;

  // Config slave word offsets
  localparam logic [4:0] CTRL         = 5'd0;
  localparam logic [4:0] PERIOD       = 5'd1;
  localparam logic [4:0] LENGTH       = 5'd2;
  localparam logic [4:0] STATUS       = 5'd3;
  localparam logic [4:0] PATTERN_BASE = 5'd16;

  // CTRL register bit positions
  localparam int CTRL_RUN_BIT     = 0;
  localparam int CTRL_ONESHOT_BIT = 1;

  // Clamp a programmed sequence length into 1..max_len
  function automatic logic [4:0] clamp_len(input logic [4:0] len, input logic [4:0] max_len);
    logic [4:0] res;
    if (len == 5'd0) begin
      res = 5'd1;
    end else if (len > max_len) begin
      res = max_len;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/led_seq_step_timer.sv
// Loadable down-counter that times how long each LED pattern is held.
module led_seq_step_timer #(
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [PERIOD_WIDTH-1:0] load_value,
  input  logic                    enable,
  output logic                    zero
);

  logic [PERIOD_WIDTH-1:0] count_r;

  // Load wins over decrement; the count parks at zero instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_value;
    end else if (enable && (count_r != '0)) begin
      count_r <= count_r - PERIOD_WIDTH'(1);
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/led_pio_sequencer.sv
// Autonomous LED pattern sequencer: a CPU loads a pattern table over a small
// Avalon-MM config slave, and the block then writes the PIO data register on
// a fixed step period without further CPU help.
module led_pio_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_STEPS    = 8,
  parameter int LED_WIDTH    = 4,
  parameter int PERIOD_WIDTH = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  cfg_address,
  input  logic        cfg_write,
  input  logic [31:0] cfg_writedata,
  input  logic        cfg_read,
  output logic [31:0] cfg_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        busy
);

  localparam int IDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [4:0] NUM_STEPS_L = 5'(NUM_STEPS);
  localparam logic [PERIOD_WIDTH-1:0] MIN_PERIOD = PERIOD_WIDTH'(2);

  // Config registers
  logic                    run_r;
  logic                    oneshot_r;
  logic [PERIOD_WIDTH-1:0] period_r;
  logic [4:0]              length_r;
  logic [LED_WIDTH-1:0]    pattern_r [NUM_STEPS];
  logic [31:0]             cfg_readdata_r;
  logic [31:0]             rd_mux_s;

  // Address decode
  logic [3:0] pat_off_s;
  logic       pat_hit_s;

  // FSM and step bookkeeping
  led_seq_state_e          state_r;
  led_seq_state_e          next_state_s;
  logic [IDX_W-1:0]        idx_r;
  logic [IDX_W-1:0]        next_idx_s;
  logic                    auto_clear_s;
  logic                    timer_load_s;
  logic                    timer_en_s;
  logic                    timer_zero_s;
  logic [PERIOD_WIDTH-1:0] eff_period_s;
  logic [PERIOD_WIDTH-1:0] timer_load_val_s;
  logic [4:0]              eff_len_s;
  logic [4:0]              last_idx_s;
  logic [4:0]              idx_ext_s;

  // Registered bus outputs and their next values
  logic        m_chipselect_r;
  logic        m_write_n_r;
  logic [31:0] m_writedata_r;
  logic        busy_r;
  logic        cs_nxt_s;
  logic        write_n_nxt_s;
  logic [31:0] data_nxt_s;
  logic        busy_nxt_s;

  // Upper write-data bits that no register stores
  logic unused_s;
  assign unused_s = ^cfg_writedata;

  assign pat_off_s = cfg_address[3:0];
  assign pat_hit_s = cfg_address[4] && ({1'b0, pat_off_s} < NUM_STEPS_L);

  // A zero/one period would leave no room for the write cycle, so two is the floor
  assign eff_period_s     = (period_r < MIN_PERIOD) ? MIN_PERIOD : period_r;
  assign timer_load_val_s = eff_period_s - MIN_PERIOD;
  assign eff_len_s        = clamp_len(length_r, NUM_STEPS_L);
  assign last_idx_s       = eff_len_s - 5'd1;
  assign idx_ext_s        = 5'(idx_r);

  led_seq_step_timer #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_step_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load_s),
    .load_value(timer_load_val_s),
    .enable    (timer_en_s),
    .zero      (timer_zero_s)
  );

  // Config register writes; a CPU CTRL write overrides the one-shot auto-clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_r     <= 1'b0;
      oneshot_r <= 1'b0;
      period_r  <= '0;
      length_r  <= 5'd0;
      for (int i = 0; i < NUM_STEPS; i++) begin
        pattern_r[i] <= '0;
      end
    end else begin
      if (cfg_write && (cfg_address == CTRL)) begin
        run_r     <= cfg_writedata[CTRL_RUN_BIT];
        oneshot_r <= cfg_writedata[CTRL_ONESHOT_BIT];
      end else if (auto_clear_s) begin
        run_r <= 1'b0;
      end
      if (cfg_write && (cfg_address == PERIOD)) begin
        period_r <= cfg_writedata[PERIOD_WIDTH-1:0];
      end
      if (cfg_write && (cfg_address == LENGTH)) begin
        length_r <= cfg_writedata[4:0];
      end
      if (cfg_write && pat_hit_s) begin
        pattern_r[pat_off_s[IDX_W-1:0]] <= cfg_writedata[LED_WIDTH-1:0];
      end
    end
  end

  // Read mux; unmapped offsets return zero
  always_comb begin
    rd_mux_s = 32'd0;
    if (cfg_address == CTRL) begin
      rd_mux_s = {30'd0, oneshot_r, run_r};
    end else if (cfg_address == PERIOD) begin
      rd_mux_s = 32'(period_r);
    end else if (cfg_address == LENGTH) begin
      rd_mux_s = 32'(length_r);
    end else if (cfg_address == STATUS) begin
      rd_mux_s = {20'd0, 4'(idx_r), 7'd0, busy_r};
    end else if (pat_hit_s) begin
      rd_mux_s = 32'(pattern_r[pat_off_s[IDX_W-1:0]]);
    end else begin
      rd_mux_s = 32'd0;
    end
  end

  // Read data is captured on the read strobe and held until the next read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_readdata_r <= 32'd0;
    end else if (cfg_read) begin
      cfg_readdata_r <= rd_mux_s;
    end
  end

  // FSM state and step index register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= '0;
    end else begin
      state_r <= next_state_s;
      idx_r   <= next_idx_s;
    end
  end

  // Next-state logic; a write in flight always completes before stopping
  always_comb begin
    next_state_s = state_r;
    next_idx_s   = idx_r;
    auto_clear_s = 1'b0;
    timer_load_s = 1'b0;
    timer_en_s   = 1'b0;
    case (state_r)
      IDLE: begin
        next_idx_s = '0;
        if (run_r) begin
          next_state_s = WRITE;
        end else begin
          next_state_s = IDLE;
        end
      end
      WRITE: begin
        if (!m_waitrequest) begin
          timer_load_s = 1'b1;
          next_state_s = HOLD;
        end else begin
          next_state_s = WRITE;
        end
      end
      HOLD: begin
        timer_en_s = 1'b1;
        if (!run_r) begin
          next_state_s = BLANK;
        end else if (timer_zero_s) begin
          if ((idx_ext_s == last_idx_s) && oneshot_r) begin
            auto_clear_s = 1'b1;
            next_state_s = BLANK;
          end else begin
            next_state_s = WRITE;
            // >= so a LENGTH shrunk below the current step wraps straight to 0
            if (idx_ext_s >= last_idx_s) begin
              next_idx_s = '0;
            end else begin
              next_idx_s = idx_r + IDX_W'(1);
            end
          end
        end else begin
          next_state_s = HOLD;
        end
      end
      BLANK: begin
        if (!m_waitrequest) begin
          next_state_s = IDLE;
          next_idx_s   = '0;
        end else begin
          next_state_s = BLANK;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_idx_s   = '0;
      end
    endcase
  end

  // Output decode from the next state so the bus pins come straight from flops
  always_comb begin
    cs_nxt_s      = 1'b0;
    write_n_nxt_s = 1'b1;
    data_nxt_s    = 32'd0;
    case (next_state_s)
      WRITE: begin
        cs_nxt_s      = 1'b1;
        write_n_nxt_s = 1'b0;
        // Data stays frozen while the PIO stalls, even if the table is rewritten
        if (state_r == WRITE) begin
          data_nxt_s = m_writedata_r;
        end else begin
          data_nxt_s = 32'(pattern_r[next_idx_s]);
        end
      end
      BLANK: begin
        cs_nxt_s      = 1'b1;
        write_n_nxt_s = 1'b0;
        data_nxt_s    = 32'd0;
      end
      IDLE, HOLD: begin
        cs_nxt_s      = 1'b0;
        write_n_nxt_s = 1'b1;
        data_nxt_s    = 32'd0;
      end
      default: begin
        cs_nxt_s      = 1'b0;
        write_n_nxt_s = 1'b1;
        data_nxt_s    = 32'd0;
      end
    endcase
    busy_nxt_s = (next_state_s != IDLE);
  end

  // Bus output registers; reset drops any partial write immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_chipselect_r <= 1'b0;
      m_write_n_r    <= 1'b1;
      m_writedata_r  <= 32'd0;
      busy_r         <= 1'b0;
    end else begin
      m_chipselect_r <= cs_nxt_s;
      m_write_n_r    <= write_n_nxt_s;
      m_writedata_r  <= data_nxt_s;
      busy_r         <= busy_nxt_s;
    end
  end

  assign m_address    = 2'd0;
  assign m_chipselect = m_chipselect_r;
  assign m_write_n    = m_write_n_r;
  assign m_writedata  = m_writedata_r;
  assign busy         = busy_r;
  assign cfg_readdata = cfg_readdata_r;

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Self-checking bench for led_pio_sequencer: a monitor logs every accepted PIO
// write with its cycle number, and each test pushes the writes it expects
// (data plus spacing from the previous write) and compares them in order.
module tb_led_pio_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  cfg_address;
  logic        cfg_write;
  logic [31:0] cfg_writedata;
  logic        cfg_read;
  logic [31:0] cfg_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic        busy;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  addr;
    int          cyc;
  } obs_t;

  typedef struct {
    logic [31:0] data;
    int          gap;
  } exp_t;

  obs_t obs_q[$];
  exp_t exp_q[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   chk_cnt = 0;
  int   ref_cyc = 0;

  led_pio_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_address  (cfg_address),
    .cfg_write    (cfg_write),
    .cfg_writedata(cfg_writedata),
    .cfg_read     (cfg_read),
    .cfg_readdata (cfg_readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .m_waitrequest(m_waitrequest),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // log every accepted PIO write
  always @(negedge clk) begin
    if (!reset && m_chipselect && !m_write_n && !m_waitrequest) begin
      obs_q.push_back('{m_writedata, m_address, cyc});
    end
  end

  task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
    cfg_address   = a;
    cfg_writedata = d;
    cfg_write     = 1'b1;
    @(posedge clk);
    #1 cfg_write  = 1'b0;
  endtask

  task automatic cfg_rd(input logic [4:0] a, output logic [31:0] d);
    cfg_address = a;
    cfg_read    = 1'b1;
    @(posedge clk);
    #1 cfg_read = 1'b0;
    d = cfg_readdata;
  endtask

  task automatic wait_obs(input int n);
    for (int c = 0; c < 300; c++) begin
      if (obs_q.size() >= n) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic stop_seq();
    cfg_wr(5'd0, 32'd0);
    for (int c = 0; c < 50; c++) begin
      if (!busy) break;
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic load_basic();
    cfg_wr(5'd16, 32'd1);
    cfg_wr(5'd17, 32'd2);
    cfg_wr(5'd18, 32'd4);
    cfg_wr(5'd19, 32'd8);
    cfg_wr(5'd2, 32'd4);
    cfg_wr(5'd1, 32'd5);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    chk_cnt++;
    if (m_chipselect !== 1'b0 || m_write_n !== 1'b1 || m_address !== 2'd0)
      $display("FAIL reset_bus: got cs=%b wn=%b addr=%0d, expected cs=0 wn=1 addr=0", m_chipselect, m_write_n, m_address);
    else pass_cnt++;
    chk_cnt++;
    if (m_writedata !== 32'd0) $display("FAIL reset_data: got %0h, expected 0", m_writedata);
    else pass_cnt++;
    chk_cnt++;
    if (cfg_readdata !== 32'd0) $display("FAIL reset_readdata: got %0h, expected 0", cfg_readdata);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy);
    else pass_cnt++;
    cfg_rd(5'd3, rd);
    chk_cnt++;
    if (rd !== 32'd0) $display("FAIL reset_status: got %0h, expected 0", rd);
    else pass_cnt++;
    repeat (5) @(posedge clk);
    #1;
    chk_cnt++;
    if (obs_q.size() != 0) $display("FAIL reset_no_write: got %0d writes, expected 0", obs_q.size());
    else pass_cnt++;
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    logic [31:0] addrs [6];
    logic [31:0] wdata [6];
    logic [31:0] expv  [6];
    addrs = '{32'd1, 32'd2, 32'd23, 32'd4, 32'd24, 32'd3};
    wdata = '{32'h12345678, 32'h000000FF, 32'h000000F7, 32'hFFFFFFFF, 32'h0000000F, 32'hFFFFFFFF};
    expv  = '{32'h00345678, 32'h0000001F, 32'h00000007, 32'h00000000, 32'h00000000, 32'h00000000};
    for (int i = 0; i < 6; i++) begin
      cfg_wr(addrs[i][4:0], wdata[i]);
      cfg_rd(addrs[i][4:0], rd);
      chk_cnt++;
      if (rd !== expv[i]) $display("FAIL regs_addr%0d: got %0h, expected %0h", addrs[i], rd, expv[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_run();
    exp_t e;
    obs_t o;
    int   prev;
    int   busy_low = 0;
    logic [31:0] seq [6];
    seq = '{32'd1, 32'd2, 32'd4, 32'd8, 32'd1, 32'd2};
    load_basic();
    cfg_wr(5'd0, 32'd1);
    ref_cyc = cyc;
    for (int k = 0; k < 6; k++) exp_q.push_back('{seq[k], (k == 0) ? 1 : 5});
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b1) busy_low++;
      if (obs_q.size() >= 6) break;
    end
    chk_cnt++;
    if (busy_low != 0) $display("FAIL run_busy: busy low in %0d cycles, expected 0", busy_low);
    else pass_cnt++;
    prev = ref_cyc;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_q.size() == 0) $display("FAIL run_write: got no write, expected data=%0h", e.data);
      else begin
        o = obs_q.pop_front();
        if (o.data !== e.data || o.addr !== 2'd0 || (o.cyc - prev) != e.gap)
          $display("FAIL run_write: got data=%0h addr=%0d gap=%0d, expected data=%0h addr=0 gap=%0d", o.data, o.addr, o.cyc - prev, e.data, e.gap);
        else pass_cnt++;
        prev = o.cyc;
      end
    end
    stop_seq();
  endtask

  task automatic test_oneshot();
    exp_t e;
    obs_t o;
    int   prev;
    logic [31:0] rd;
    logic [31:0] seq [5];
    seq = '{32'd1, 32'd2, 32'd4, 32'd8, 32'd0};
    cfg_wr(5'd0, 32'd3);
    ref_cyc = cyc;
    for (int k = 0; k < 5; k++) exp_q.push_back('{seq[k], (k == 0) ? 1 : 5});
    wait_obs(5);
    repeat (12) @(posedge clk);
    #1;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL oneshot_busy: got %b, expected 0", busy);
    else pass_cnt++;
    chk_cnt++;
    if (obs_q.size() != 5) $display("FAIL oneshot_count: got %0d writes, expected 5", obs_q.size());
    else pass_cnt++;
    prev = ref_cyc;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_q.size() == 0) $display("FAIL oneshot_write: got no write, expected data=%0h", e.data);
      else begin
        o = obs_q.pop_front();
        if (o.data !== e.data || o.addr !== 2'd0 || (o.cyc - prev) != e.gap)
          $display("FAIL oneshot_write: got data=%0h addr=%0d gap=%0d, expected data=%0h addr=0 gap=%0d", o.data, o.addr, o.cyc - prev, e.data, e.gap);
        else pass_cnt++;
        prev = o.cyc;
      end
    end
    cfg_rd(5'd0, rd);
    // run bit must have been auto-cleared
    chk_cnt++;
    if (rd[0] !== 1'b0) $display("FAIL oneshot_ctrl_run: got %b, expected 0", rd[0]);
    else pass_cnt++;
    stop_seq();
  endtask

  task automatic test_stop_in_hold();
    exp_t e;
    obs_t o;
    int   prev;
    cfg_wr(5'd0, 32'd1);
    ref_cyc = cyc;
    exp_q.push_back('{32'd1, 1});
    exp_q.push_back('{32'd2, 5});
    // stop lands two cycles into HOLD, BLANK follows one cycle later
    exp_q.push_back('{32'd0, 3});
    wait_obs(2);
    cfg_wr(5'd0, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL stop_busy: got %b, expected 0", busy);
    else pass_cnt++;
    prev = ref_cyc;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_q.size() == 0) $display("FAIL stop_write: got no write, expected data=%0h", e.data);
      else begin
        o = obs_q.pop_front();
        if (o.data !== e.data || o.addr !== 2'd0 || (o.cyc - prev) != e.gap)
          $display("FAIL stop_write: got data=%0h addr=%0d gap=%0d, expected data=%0h addr=0 gap=%0d", o.data, o.addr, o.cyc - prev, e.data, e.gap);
        else pass_cnt++;
        prev = o.cyc;
      end
    end
    chk_cnt++;
    if (obs_q.size() != 0) $display("FAIL stop_extra: got %0d extra writes, expected 0", obs_q.size());
    else pass_cnt++;
    obs_q.delete();
  endtask

  task automatic test_min_period_len();
    exp_t e;
    obs_t o;
    int   prev;
    cfg_wr(5'd1, 32'd0);
    cfg_wr(5'd2, 32'd0);
    cfg_wr(5'd0, 32'd1);
    ref_cyc = cyc;
    for (int k = 0; k < 4; k++) exp_q.push_back('{32'd1, (k == 0) ? 1 : 2});
    wait_obs(4);
    prev = ref_cyc;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_q.size() == 0) $display("FAIL minper_write: got no write, expected data=%0h", e.data);
      else begin
        o = obs_q.pop_front();
        if (o.data !== e.data || o.addr !== 2'd0 || (o.cyc - prev) != e.gap)
          $display("FAIL minper_write: got data=%0h addr=%0d gap=%0d, expected data=%0h addr=0 gap=%0d", o.data, o.addr, o.cyc - prev, e.data, e.gap);
        else pass_cnt++;
        prev = o.cyc;
      end
    end
    stop_seq();
  endtask

  task automatic test_waitrequest();
    exp_t e;
    obs_t o;
    int   prev;
    load_basic();
    m_waitrequest = 1'b1;
    cfg_wr(5'd0, 32'd1);
    ref_cyc = cyc;
    exp_q.push_back('{32'd1, 4});
    exp_q.push_back('{32'd2, 5});
    exp_q.push_back('{32'd4, 5});
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk_cnt++;
      if (m_chipselect !== 1'b1 || m_write_n !== 1'b0 || m_writedata !== 32'd1)
        $display("FAIL stall_cycle%0d: got cs=%b wn=%b data=%0h, expected cs=1 wn=0 data=1", k, m_chipselect, m_write_n, m_writedata);
      else pass_cnt++;
    end
    m_waitrequest = 1'b0;
    wait_obs(3);
    prev = ref_cyc;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_q.size() == 0) $display("FAIL stall_write: got no write, expected data=%0h", e.data);
      else begin
        o = obs_q.pop_front();
        if (o.data !== e.data || o.addr !== 2'd0 || (o.cyc - prev) != e.gap)
          $display("FAIL stall_write: got data=%0h addr=%0d gap=%0d, expected data=%0h addr=0 gap=%0d", o.data, o.addr, o.cyc - prev, e.data, e.gap);
        else pass_cnt++;
        prev = o.cyc;
      end
    end
    stop_seq();
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd;
    logic [4:0]  addrs [4];
    addrs = '{5'd0, 5'd1, 5'd2, 5'd16};
    load_basic();
    m_waitrequest = 1'b1;
    cfg_wr(5'd0, 32'd1);
    @(posedge clk);
    #1;
    chk_cnt++;
    if (m_chipselect !== 1'b1) $display("FAIL rstmid_pre_cs: got %b, expected 1", m_chipselect);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    chk_cnt++;
    if (m_chipselect !== 1'b0 || m_write_n !== 1'b1 || busy !== 1'b0 || m_writedata !== 32'd0)
      $display("FAIL rstmid_outputs: got cs=%b wn=%b busy=%b data=%0h, expected cs=0 wn=1 busy=0 data=0", m_chipselect, m_write_n, busy, m_writedata);
    else pass_cnt++;
    @(posedge clk);
    #1 reset = 1'b0;
    m_waitrequest = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 4; i++) begin
      cfg_rd(addrs[i], rd);
      chk_cnt++;
      if (rd !== 32'd0) $display("FAIL rstmid_reg%0d: got %0h, expected 0", addrs[i], rd);
      else pass_cnt++;
    end
    repeat (10) @(posedge clk);
    #1;
    chk_cnt++;
    if (obs_q.size() != 0) $display("FAIL rstmid_no_write: got %0d writes, expected 0", obs_q.size());
    else pass_cnt++;
  endtask

  initial begin
    reset         = 1'b1;
    cfg_address   = 5'd0;
    cfg_write     = 1'b0;
    cfg_writedata = 32'd0;
    cfg_read      = 1'b0;
    m_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_regs();
    test_run();
    test_oneshot();
    test_stop_in_hold();
    test_min_period_len();
    test_waitrequest();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
